count_seq_decoder: RTL and testbench
====================================

Name: count_seq_decoder

Overview:
- Receive-side partner to the team's JK-based up/down counters (mode input m: 0 = up, 1 = down).
- Samples a WIDTH-bit count bus and reconstructs the count direction.
- Keeps a wider signed-agnostic position accumulator and flags illegal jumps.
- Sits on the observer side of any counter bus, e.g. a self-check on the 3-bit up/down counter or a position tracker fed by an external counter.

Parameters:
- WIDTH, 3: width of the observed count bus q_in; the count is interpreted modulo 2^WIDTH.
- POS_W, 8: width of the position accumulator; it wraps modulo 2^POS_W.
- LOCK_STEPS, 2: consecutive legal non-zero steps required before valid is asserted.
- ERR_W, 4: width of the saturating error counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clear  input  1  asynchronous active-low reset.
- q_in  input  WIDTH  observed count value; sampled only when sample_en=1.
- sample_en  input  1  sample strobe, one cycle per sample.
- dir  output  1  last detected direction; 0 = up, 1 = down (same convention as m).
- valid  output  1  decoder is locked; position and dir are meaningful.
- position  output  POS_W  accumulated step count.
- step_err  output  1  one-cycle pulse on an illegal jump.
- err_count  output  ERR_W  saturating count of illegal jumps.

Behaviour:
- Clock and reset: one clock, clk. Reset clear is asynchronous and active-low.
- Reset values: state=ACQUIRE, prev=0, lock_cnt=0, dir=0, valid=0, position=0, step_err=0, err_count=0.
- Outputs are registered. The effect of a sample appears one clk after the sample_en cycle. With sample_en=0, all state holds and step_err=0.
- delta = (q_in - prev) mod 2^WIDTH. Step classes:
  - ZERO: delta=0.
  - UP: delta=1.
  - DOWN: delta=2^WIDTH-1.
  - ILLEGAL: any other delta.
- Wrap-around is legal: 7->0 is UP and 0->7 is DOWN (WIDTH=3).
- FSM ACQUIRE:
  - On sample_en: prev<=q_in, lock_cnt<=0, go to LOCK.
  - No position change, valid=0.
- FSM LOCK, on sample_en:
  - ZERO: hold everything.
  - UP/DOWN: prev<=q_in; dir updated; position += 1 for UP or -= 1 for DOWN; lock_cnt++.
  - When lock_cnt reaches LOCK_STEPS: go to TRACK and set valid=1 in the same update.
  - ILLEGAL: step_err pulse, err_count++, prev<=q_in, lock_cnt<=0, stay in LOCK.
- FSM TRACK, on sample_en:
  - ZERO: hold.
  - UP/DOWN: prev<=q_in; position +/- 1; dir updated.
  - A direction reversal is legal and needs no relock.
  - ILLEGAL: step_err pulse, err_count++, prev<=q_in, lock_cnt<=0, valid<=0, go to LOCK. Position is not modified.
- position wraps modulo 2^POS_W in both directions (0 - 1 = 2^POS_W-1).
- err_count saturates at 2^ERR_W-1 and is cleared only by reset.
- Reset asserted mid-operation returns all state to the reset values immediately, regardless of clk. The first sample after reset release is always absorbed by ACQUIRE.
- With LOCK_STEPS=0: LOCK passes to TRACK on the first legal non-zero step. That step still updates position.

Optional Feature:
- Macro: COUNT_SEQ_GLITCH_FILTER_EN.
- When defined:
  - A sampled q_in is accepted only after the same value is seen on two consecutive sample_en strobes. A one-strobe glitch is discarded without step_err.
  - Latency from the first strobe of a new value becomes the second strobe plus one clk.
  - ACQUIRE also needs two matching strobes.
- When undefined: every strobe is processed directly as described above.

Decomposition:
- Shared package count_seq_pkg holds:
  - State enum: ACQUIRE, LOCK, TRACK.
  - Step-class enum: ZERO, UP, DOWN, ILLEGAL.
  - Direction constants DIR_UP=0, DIR_DOWN=1.
- One sub-module, count_step_classify: combinational; takes prev and q_in, returns the step class. It is reused by the counter self-check benches.

Test Plan:
- Reset, then q_in 0,1,2,3 on strobes (WIDTH=3, LOCK_STEPS=2) -> valid rises after the strobe with q_in=2, position=3, dir=0.
- Locked at q_in=1, then strobe 0, then strobe 7 -> position decrements twice, dir=1, 7 is accepted as DOWN via wrap, step_err=0.
- Locked, then q_in jumps 2->5 -> step_err pulses exactly one clk, err_count=1, valid=0; position unchanged; relock after two legal steps from 5.
- Position at 0 with a DOWN step -> position=255 (POS_W=8); at 255 with an UP step -> 0.
- Force 20 illegal jumps (ERR_W=4) -> err_count stops at 15.
- clear pulsed low mid-TRACK between clk edges -> all outputs 0 immediately. With COUNT_SEQ_GLITCH_FILTER_EN defined, the single-strobe glitch in 3,6,3,4 is ignored with no step_err.

Source files
------------

// File: rtl/count_seq_pkg.sv
// Shared types for the count-sequence decoder: FSM states, step classes, direction codes.
package count_seq_pkg;

    typedef enum logic [1:0] {
        ACQUIRE,
        LOCK,
        TRACK
    } seq_state_t;

    typedef enum logic [1:0] {
        ZERO,
        UP,
        DOWN,
        ILLEGAL
    } step_class_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/count_step_classify.sv
// Combinational step classifier: compares a new count against the previous one modulo 2^WIDTH.
module count_step_classify
    import count_seq_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] q_in,
    output step_class_t      step
);

    logic [WIDTH-1:0] delta;

    always_comb begin
        delta = q_in - prev;
        // UP is tested before DOWN so a 1-bit bus, where both deltas coincide, reads as UP
        if (delta == '0)
            step = ZERO;
        else if (delta == WIDTH'(1))
            step = UP;
        else if (delta == '1)
            step = DOWN;
        else
            step = ILLEGAL;
    end

endmodule

// File: rtl/count_seq_decoder.sv
// Observer for up/down counter buses: recovers direction, tracks position, flags illegal jumps.
// Optional COUNT_SEQ_GLITCH_FILTER_EN: a value is accepted only after two matching strobes.
module count_seq_decoder
    import count_seq_pkg::*;
#(
    parameter int WIDTH      = 3,
    parameter int POS_W      = 8,
    parameter int LOCK_STEPS = 2,
    parameter int ERR_W      = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] q_in,
    input  logic             sample_en,
    output logic             dir,
    output logic             valid,
    output logic [POS_W-1:0] position,
    output logic             step_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int              LCW      = $clog2(LOCK_STEPS + 1) + 1;
    localparam logic [LCW-1:0]  LOCK_TGT = LCW'(LOCK_STEPS);

    seq_state_t       state, state_nxt;
    step_class_t      step;
    logic [WIDTH-1:0] prev, prev_nxt;
    logic [LCW-1:0]   lock_cnt, lock_nxt, lock_inc;
    logic             dir_nxt, valid_nxt, step_err_nxt;
    logic [POS_W-1:0] pos_nxt;
    logic [ERR_W-1:0] err_nxt;
    logic             accept;

`ifdef COUNT_SEQ_GLITCH_FILTER_EN
    logic [WIDTH-1:0] cand;
    logic             cand_ok;

    // Every strobe becomes the new candidate; a strobe matching the previous one is accepted
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            cand    <= '0;
            cand_ok <= 1'b0;
        end else if (sample_en) begin
            cand    <= q_in;
            cand_ok <= 1'b1;
        end
    end

    assign accept = sample_en && cand_ok && (q_in == cand);
`else
    assign accept = sample_en;
`endif

    count_step_classify #(.WIDTH(WIDTH)) u_classify (
        .prev (prev),
        .q_in (q_in),
        .step (step)
    );

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state     <= ACQUIRE;
            prev      <= '0;
            lock_cnt  <= '0;
            dir       <= DIR_UP;
            valid     <= 1'b0;
            position  <= '0;
            step_err  <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            prev      <= prev_nxt;
            lock_cnt  <= lock_nxt;
            dir       <= dir_nxt;
            valid     <= valid_nxt;
            position  <= pos_nxt;
            step_err  <= step_err_nxt;
            err_count <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        prev_nxt     = prev;
        lock_nxt     = lock_cnt;
        dir_nxt      = dir;
        valid_nxt    = valid;
        pos_nxt      = position;
        err_nxt      = err_count;
        step_err_nxt = 1'b0;
        lock_inc     = lock_cnt + 1'b1;

        if (accept) begin
            unique case (state)
                ACQUIRE: begin
                    prev_nxt  = q_in;
                    lock_nxt  = '0;
                    state_nxt = LOCK;
                end
                LOCK, TRACK: begin
                    unique case (step)
                        ZERO: begin
                        end
                        UP, DOWN: begin
                            prev_nxt = q_in;
                            dir_nxt  = (step == DOWN) ? DIR_DOWN : DIR_UP;
                            pos_nxt  = (step == DOWN) ? position - POS_W'(1)
                                                      : position + POS_W'(1);
                            if (state == LOCK) begin
                                lock_nxt = lock_inc;
                                if (lock_inc >= LOCK_TGT) begin
                                    state_nxt = TRACK;
                                    valid_nxt = 1'b1;
                                end
                            end
                        end
                        default: begin
                            step_err_nxt = 1'b1;
                            if (err_count != '1)
                                err_nxt = err_count + 1'b1;
                            prev_nxt  = q_in;
                            lock_nxt  = '0;
                            valid_nxt = 1'b0;
                            state_nxt = LOCK;
                        end
                    endcase
                end
                default: state_nxt = ACQUIRE;
            endcase
        end
    end

endmodule

// File: tb/tb_count_seq_decoder.sv
// Self-checking bench for count_seq_decoder; honours COUNT_SEQ_GLITCH_FILTER_EN when defined.
module tb_count_seq_decoder;

`ifdef COUNT_SEQ_GLITCH_FILTER_EN
    localparam int unsigned REPS = 2;
    localparam bit          FILT = 1'b1;
`else
    localparam int unsigned REPS = 1;
    localparam bit          FILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clear;
    logic [2:0] q_in;
    logic       sample_en;
    logic       dir, valid, step_err;
    logic [7:0] position;
    logic [3:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain arithmetic on the observed sample stream
    bit         m_synced;
    int         m_prev;
    int         m_run;
    bit         m_valid;
    int         m_pos;
    bit         m_dir;
    int         m_err;
    bit         m_step_err;
    bit         m_have_raw;
    int         m_raw;

    always #5 clk = ~clk;

    count_seq_decoder #(
        .WIDTH      (3),
        .POS_W      (8),
        .LOCK_STEPS (2),
        .ERR_W      (4)
    ) dut (
        .clk       (clk),
        .clear     (clear),
        .q_in      (q_in),
        .sample_en (sample_en),
        .dir       (dir),
        .valid     (valid),
        .position  (position),
        .step_err  (step_err),
        .err_count (err_count)
    );

    task automatic model_reset();
        m_synced = 0; m_prev = 0; m_run = 0; m_valid = 0; m_pos = 0;
        m_dir = 0; m_err = 0; m_step_err = 0; m_have_raw = 0; m_raw = 0;
    endtask

    task automatic model_sample(input int v);
        int d;
        m_step_err = 0;
        if (FILT) begin
            if (!m_have_raw || v != m_raw) begin
                m_have_raw = 1;
                m_raw = v;
                return;
            end
        end
        if (!m_synced) begin
            m_synced = 1; m_prev = v; m_run = 0;
            return;
        end
        d = (v - m_prev + 8) % 8;
        if (d == 0) return;
        if (d == 1 || d == 7) begin
            m_pos = (d == 1) ? (m_pos + 1) % 256 : (m_pos + 255) % 256;
            m_dir = (d == 7);
            m_prev = v;
            if (!m_valid) begin
                m_run++;
                if (m_run >= 2) m_valid = 1;
            end
        end else begin
            m_step_err = 1;
            if (m_err < 15) m_err++;
            m_prev = v; m_run = 0; m_valid = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear = 1'b0; sample_en = 1'b0; q_in = '0;
        @(negedge clk);
        clear = 1'b1;
        model_reset();
    endtask

    task automatic raw_strobe(input logic [2:0] v);
        @(negedge clk);
        q_in = v; sample_en = 1'b1;
        @(negedge clk);
        sample_en = 1'b0;
        model_sample(int'(v));
    endtask

    task automatic strobe(input logic [2:0] v);
        for (int unsigned r = 0; r < REPS; r++) raw_strobe(v);
    endtask

    task automatic test_reset();
        @(negedge clk);
        clear = 1'b0; sample_en = 1'b0; q_in = 3'd5;
        #1;
        n_tests++;
        if ({dir, valid, position, step_err, err_count} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", {dir, valid, position, step_err, err_count});
        end
        @(negedge clk);
        clear = 1'b1;
        model_reset();
    endtask

    task automatic test_lock_up();
        do_reset();
        strobe(3'd0);
        strobe(3'd1);
        n_tests++;
        if (valid !== 1'b0 || position !== 8'd1) begin
            n_fail++;
            $display("FAIL lock_step1: valid=%b pos=%0d want valid=0 pos=1", valid, position);
        end
        strobe(3'd2);
        n_tests++;
        if (valid !== 1'b1 || position !== 8'd2) begin
            n_fail++;
            $display("FAIL lock_step2: valid=%b pos=%0d want valid=1 pos=2", valid, position);
        end
        strobe(3'd3);
        n_tests++;
        if (position !== 8'd3 || dir !== 1'b0 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL track_up: pos=%0d dir=%b valid=%b want 3 0 1", position, dir, valid);
        end
    endtask

    task automatic test_down_wrap();
        strobe(3'd2);
        strobe(3'd1);
        n_tests++;
        if (position !== 8'd1 || dir !== 1'b1) begin
            n_fail++;
            $display("FAIL reverse: pos=%0d dir=%b want 1 1", position, dir);
        end
        strobe(3'd0);
        strobe(3'd7);
        n_tests++;
        if (position !== 8'd255 || dir !== 1'b1 || step_err !== 1'b0 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL down_wrap: pos=%0d dir=%b err=%b valid=%b want 255 1 0 1",
                     position, dir, step_err, valid);
        end
        strobe(3'd0);
        n_tests++;
        if (position !== 8'd0 || dir !== 1'b0) begin
            n_fail++;
            $display("FAIL up_wrap: pos=%0d dir=%b want 0 0", position, dir);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        strobe(3'd0);
        strobe(3'd1);
        strobe(3'd2);
        strobe(3'd5);
        n_tests++;
        if (step_err !== 1'b1 || err_count !== 4'd1 || valid !== 1'b0 || position !== 8'd2) begin
            n_fail++;
            $display("FAIL illegal_jump: err=%b cnt=%0d valid=%b pos=%0d want 1 1 0 2",
                     step_err, err_count, valid, position);
        end
        @(negedge clk);
        n_tests++;
        if (step_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_pulse_width: step_err=%b want 0", step_err);
        end
        strobe(3'd6);
        n_tests++;
        if (valid !== 1'b0 || position !== 8'd3) begin
            n_fail++;
            $display("FAIL relock1: valid=%b pos=%0d want 0 3", valid, position);
        end
        strobe(3'd7);
        n_tests++;
        if (valid !== 1'b1 || position !== 8'd4 || err_count !== 4'd1) begin
            n_fail++;
            $display("FAIL relock2: valid=%b pos=%0d cnt=%0d want 1 4 1", valid, position, err_count);
        end
    endtask

    task automatic test_err_saturate();
        do_reset();
        strobe(3'd0);
        for (int unsigned i = 0; i < 20; i++) begin
            strobe((i % 2 == 0) ? 3'd4 : 3'd0);
            if (i == 14) begin
                n_tests++;
                if (err_count !== 4'd15) begin
                    n_fail++;
                    $display("FAIL err_reach15: cnt=%0d want 15", err_count);
                end
            end
        end
        n_tests++;
        if (err_count !== 4'd15 || position !== 8'd0) begin
            n_fail++;
            $display("FAIL err_saturate: cnt=%0d pos=%0d want 15 0", err_count, position);
        end
    endtask

    task automatic test_async_clear();
        do_reset();
        strobe(3'd0);
        strobe(3'd1);
        strobe(3'd2);
        strobe(3'd1);
        strobe(3'd4);
        strobe(3'd5);
        strobe(3'd6);
        @(negedge clk);
        #2 clear = 1'b0;
        #1;
        n_tests++;
        if ({dir, valid, position, step_err, err_count} !== 15'd0) begin
            n_fail++;
            $display("FAIL async_clear: got %h want 0", {dir, valid, position, step_err, err_count});
        end
        @(negedge clk);
        clear = 1'b1;
        model_reset();
        strobe(3'd6);
        n_tests++;
        if (valid !== 1'b0 || position !== 8'd0 || step_err !== 1'b0) begin
            n_fail++;
            $display("FAIL post_clear_acquire: valid=%b pos=%0d err=%b want 0 0 0", valid, position, step_err);
        end
    endtask

`ifdef COUNT_SEQ_GLITCH_FILTER_EN
    task automatic test_glitch();
        do_reset();
        strobe(3'd2);
        strobe(3'd3);
        raw_strobe(3'd6);
        n_tests++;
        if (step_err !== 1'b0 || position !== 8'd1) begin
            n_fail++;
            $display("FAIL glitch_ignored: err=%b pos=%0d want 0 1", step_err, position);
        end
        raw_strobe(3'd3);
        raw_strobe(3'd4);
        raw_strobe(3'd4);
        n_tests++;
        if (step_err !== 1'b0 || position !== 8'd2 || err_count !== 4'd0) begin
            n_fail++;
            $display("FAIL glitch_followup: err=%b pos=%0d cnt=%0d want 0 2 0", step_err, position, err_count);
        end
    endtask
`endif

    task automatic test_random();
        logic [2:0] lv;
        int unsigned r;
        do_reset();
        lv = 3'($urandom_range(0, 7));
        for (int unsigned i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                @(negedge clk);
                m_step_err = 0;
            end else begin
                if (r <= 3)      lv = lv + 3'd1;
                else if (r <= 6) lv = lv - 3'd1;
                else if (r == 7) lv = lv;
                else             lv = 3'($urandom_range(0, 7));
                if (r == 7 || !FILT) raw_strobe(lv);
                else if ($urandom_range(0, 3) == 0) raw_strobe(lv);
                else strobe(lv);
            end
            n_tests++;
            if ({dir, valid, position, step_err, err_count} !==
                {m_dir, m_valid, 8'(m_pos), m_step_err, 4'(m_err)}) begin
                n_fail++;
                $display("FAIL random[%0d]: dir/valid/pos/err/cnt got %b %b %0d %b %0d want %b %b %0d %b %0d",
                         i, dir, valid, position, step_err, err_count,
                         m_dir, m_valid, m_pos, m_step_err, m_err);
            end
        end
    endtask

    initial begin
        clear = 1'b0; sample_en = 1'b0; q_in = '0;
        model_reset();
        test_reset();
        test_lock_up();
        test_down_wrap();
        test_illegal();
        test_err_saturate();
        test_async_clear();
`ifdef COUNT_SEQ_GLITCH_FILTER_EN
        test_glitch();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
